// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arithmetic/shift ops; unsigned multiply is iterative
// shift-add, one multiplier bit per clock. Results and flags are held
// until the consumer takes them.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int CNT_W = SHW + 1;

  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  // Everything presented to the consumer, registered as one bundle.
  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             err;
  } res_t;

  // Result of every single-cycle op; MUL never reaches here, and any
  // opcode without a case item is illegal (y=0, err=1, zero=1).
  function automatic res_t simple_op(input logic [3:0]       op_v,
                                     input logic [WIDTH-1:0] a_v,
                                     input logic [WIDTH-1:0] b_v);
    res_t       r;
    logic [WIDTH:0] ext;
    r   = '0;
    ext = '0;
    case (op_v)
      OP_INC: begin
        ext     = {1'b0, b_v} + (WIDTH+1)'(1);
        r.y     = ext[WIDTH-1:0];
        r.carry = ext[WIDTH];
        r.ovf   = ~b_v[WIDTH-1] & r.y[WIDTH-1];
      end
      OP_ADD: begin
        ext     = {1'b0, a_v} + {1'b0, b_v};
        r.y     = ext[WIDTH-1:0];
        r.carry = ext[WIDTH];
        r.ovf   = (a_v[WIDTH-1] == b_v[WIDTH-1]) && (r.y[WIDTH-1] != a_v[WIDTH-1]);
      end
      OP_SUB: begin
        // MSB of the widened difference is the borrow (a < b unsigned).
        ext     = {1'b0, a_v} - {1'b0, b_v};
        r.y     = ext[WIDTH-1:0];
        r.carry = ext[WIDTH];
        r.ovf   = (a_v[WIDTH-1] != b_v[WIDTH-1]) && (r.y[WIDTH-1] != a_v[WIDTH-1]);
      end
      OP_XOR:  r.y = a_v ^ b_v;
      OP_AND:  r.y = a_v & b_v;
      OP_OR:   r.y = a_v | b_v;
      OP_SHL:  r.y = a_v << b_v[SHW-1:0];
      OP_SHR:  r.y = a_v >> b_v[SHW-1:0];
      default: r.err = 1'b1;
    endcase
    r.zero = (r.y == '0);
    r.neg  = r.y[WIDTH-1];
    return r;
  endfunction

  state_t             state_q,  state_d;
  res_t               res_q,    res_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic [WIDTH:0]     acc;
  logic [2*WIDTH-1:0] prod_step;
  res_t               mul_res;

  // Handshake outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    out_valid = (state_q == S_DONE);
    in_ready  = rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole product right by one.
  always_comb begin
    acc       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {acc, prod_q[WIDTH-1:1]};
    mul_res       = '0;
    mul_res.y     = prod_step[WIDTH-1:0];
    mul_res.y_hi  = prod_step[2*WIDTH-1:WIDTH];
    mul_res.zero  = (mul_res.y == '0);
    mul_res.neg   = mul_res.y[WIDTH-1];
    mul_res.carry = (mul_res.y_hi != '0);
  end

  // Next-state, operand capture and result update.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d  = state_q;
    res_d    = res_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_EXEC;
          end else begin
            res_d   = simple_op(op, a, b);
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = mul_res;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign y     = res_q.y;
  assign y_hi  = res_q.y_hi;
  assign zero  = res_q.zero;
  assign neg   = res_q.neg;
  assign carry = res_q.carry;
  assign ovf   = res_q.ovf;
  assign err   = res_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed scenarios plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] y, y_hi;
  logic         zero, neg, carry, ovf, err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         err;
  } res_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .zero(zero), .neg(neg), .carry(carry),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t dut_res();
    return res_t'{y: y, y_hi: y_hi, zero: zero, neg: neg, carry: carry, ovf: ovf, err: err};
  endfunction

  // Reference model: plain integer arithmetic on the opcode table.
  function automatic res_t model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    res_t   r;
    longint ua, ub, sa, sb, full, sfull;
    logic   [2*W-1:0] p;
    r  = '0;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    full = 0;
    sfull = 0;
    case (o)
      4'b0001, 4'b0101, 4'b0110: begin
        if (o == 4'b0001) begin full = ub + 1;  sfull = sb + 1;  end
        if (o == 4'b0101) begin full = ua + ub; sfull = sa + sb; end
        if (o == 4'b0110) begin full = ua - ub; sfull = sa - sb; end
        r.y     = full[W-1:0];
        r.carry = (o == 4'b0110) ? (ua < ub) : (full >= (64'sd1 << W));
        r.ovf   = (sfull > ((64'sd1 << (W-1)) - 1)) || (sfull < -(64'sd1 << (W-1)));
      end
      4'b0111: r.y = av ^ bv;
      4'b0010: r.y = av & bv;
      4'b0011: r.y = av | bv;
      4'b1000: r.y = av << bv[$clog2(W)-1:0];
      4'b1001: r.y = av >> bv[$clog2(W)-1:0];
      4'b1010: begin
        full    = ua * ub;
        p       = full[2*W-1:0];
        r.y     = p[W-1:0];
        r.y_hi  = p[2*W-1:W];
        r.carry = (r.y_hi != 0);
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.y == 0);
    r.neg  = r.y[W-1];
    return r;
  endfunction

  // Present one op, wait for acceptance and then for out_valid (bounded).
  // lat = edges after the accepting edge until out_valid is seen.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output bit ok, output int rdy_busy);
    int guard;
    guard = 0;
    rdy_busy = 0;
    op = o; a = av; b = bv; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      @(posedge clk); #1; lat++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, dut_res()} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h, want all zero", in_ready, out_valid, dut_res());
    end
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_ovf();
    int lat, busy; bit ok;
    res_t exp_r;
    exp_r = res_t'{y: 16'h8000, y_hi: 16'h0, zero: 0, neg: 1, carry: 0, ovf: 1, err: 0};
    issue(4'b0101, 16'h7FFF, 16'h0001, lat, ok, busy);
    n_cmp++;
    if (!ok || lat !== 0 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL add_ovf: got ok=%b lat=%0d res=%h, want lat=0 res=%h", ok, lat, dut_res(), exp_r);
    end
    consume();
  endtask

  task automatic test_sub_inc();
    int lat, busy; bit ok;
    res_t exp_r;
    exp_r = res_t'{y: 16'hFFFE, y_hi: 16'h0, zero: 0, neg: 1, carry: 1, ovf: 0, err: 0};
    issue(4'b0110, 16'h0003, 16'h0005, lat, ok, busy);
    n_cmp++;
    if (!ok || lat !== 0 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL sub_borrow: got ok=%b lat=%0d res=%h, want lat=0 res=%h", ok, lat, dut_res(), exp_r);
    end
    consume();
    exp_r = res_t'{y: 16'h0000, y_hi: 16'h0, zero: 1, neg: 0, carry: 1, ovf: 0, err: 0};
    issue(4'b0001, 16'h1234, 16'hFFFF, lat, ok, busy);
    n_cmp++;
    if (!ok || lat !== 0 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL inc_wrap: got ok=%b lat=%0d res=%h, want lat=0 res=%h", ok, lat, dut_res(), exp_r);
    end
    consume();
  endtask

  task automatic test_mul();
    int lat, busy; bit ok;
    res_t exp_r;
    exp_r = res_t'{y: 16'h3400, y_hi: 16'h0012, zero: 0, neg: 0, carry: 1, ovf: 0, err: 0};
    issue(4'b1010, 16'h1234, 16'h0100, lat, ok, busy);
    n_cmp++;
    if (!ok || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL mul_result: got ok=%b res=%h, want res=%h", ok, dut_res(), exp_r);
    end
    n_cmp++;
    if (lat !== W) begin
      n_err++;
      $display("FAIL mul_latency: got %0d edges, want %0d", lat, W);
    end
    n_cmp++;
    if (busy !== 0) begin
      n_err++;
      $display("FAIL mul_in_ready: in_ready high in %0d EXEC cycles, want 0", busy);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, busy; bit ok;
    res_t r0, exp_x;
    logic [W-1:0] av, bv;
    av = W'($urandom);
    bv = W'($urandom);
    issue(4'b0101, av, bv, lat, ok, busy);
    r0 = dut_res();
    n_cmp++;
    if (!ok || r0 !== model(4'b0101, av, bv)) begin
      n_err++;
      $display("FAIL bp_first: got ok=%b res=%h, want res=%h", ok, r0, model(4'b0101, av, bv));
    end
    in_valid = 1'b1; op = 4'b0111; a = 16'hFFFF; b = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_res() !== r0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=%h",
                 i, out_valid, in_ready, dut_res(), r0);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_comb: got in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_x = res_t'{y: 16'hFF00, y_hi: 16'h0, zero: 0, neg: 1, carry: 0, ovf: 0, err: 0};
    n_cmp++;
    if (out_valid !== 1'b1 || dut_res() !== exp_x) begin
      n_err++;
      $display("FAIL bp_same_edge_xor: got vld=%b res=%h, want vld=1 res=%h", out_valid, dut_res(), exp_x);
    end
    consume();
  endtask

  task automatic test_illegal_shr();
    int lat, busy; bit ok;
    res_t exp_r;
    exp_r = res_t'{y: 16'h0000, y_hi: 16'h0, zero: 1, neg: 0, carry: 0, ovf: 0, err: 1};
    issue(4'b1111, W'($urandom), W'($urandom), lat, ok, busy);
    n_cmp++;
    if (!ok || lat !== 0 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL illegal_op: got ok=%b lat=%0d res=%h, want lat=0 res=%h", ok, lat, dut_res(), exp_r);
    end
    consume();
    exp_r = res_t'{y: 16'h0001, y_hi: 16'h0, zero: 0, neg: 0, carry: 0, ovf: 0, err: 0};
    issue(4'b1001, 16'h8000, 16'h001F, lat, ok, busy);
    n_cmp++;
    if (!ok || lat !== 0 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL shr_mask: got ok=%b lat=%0d res=%h, want lat=0 res=%h", ok, lat, dut_res(), exp_r);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    int lat, busy, seen; bit ok;
    issue(4'b0101, 16'h0001, 16'h0001, lat, ok, busy);
    consume();
    op = 4'b1010; a = W'($urandom_range(1, 16'hFFFF)); b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W - 5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, dut_res()} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_mul: got vld=%b rdy=%b res=%h, want all zero", out_valid, in_ready, dut_res());
    end
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (out_valid || y !== '0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_no_result: got %0d cycles with a result, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] simple_ops [8];
    logic [3:0] o;
    logic [W-1:0] av, bv;
    res_t exp_r;
    bit have;
    simple_ops = '{4'b0001, 4'b0101, 4'b0110, 4'b0111, 4'b0010, 4'b0011, 4'b1000, 4'b1001};
    have = 1'b0;
    exp_r = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      o  = simple_ops[$urandom_range(0, 7)];
      av = W'($urandom);
      bv = W'($urandom);
      if (have) begin
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || dut_res() !== exp_r) begin
          n_err++;
          $display("FAIL b2b_%0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=1 res=%h",
                   i, out_valid, in_ready, dut_res(), exp_r);
        end
      end
      op = o; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      exp_r = model(o, av, bv);
      have = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || dut_res() !== exp_r) begin
      n_err++;
      $display("FAIL b2b_last: got vld=%b res=%h, want vld=1 res=%h", out_valid, dut_res(), exp_r);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    int lat, busy; bit ok;
    logic [3:0] o;
    logic [W-1:0] av, bv;
    res_t exp_r;
    int exp_lat;
    for (int i = 0; i < 40; i++) begin
      o  = ($urandom_range(0, 3) == 0) ? 4'b1010 : 4'($urandom);
      av = W'($urandom);
      bv = W'($urandom);
      exp_r   = model(o, av, bv);
      exp_lat = (o == 4'b1010) ? W : 0;
      issue(o, av, bv, lat, ok, busy);
      n_cmp++;
      if (!ok || lat !== exp_lat || busy !== 0 || dut_res() !== exp_r) begin
        n_err++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: got ok=%b lat=%0d busy=%0d res=%h, want lat=%0d res=%h",
                 i, o, av, bv, ok, lat, busy, dut_res(), exp_lat, exp_r);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_inc();
    test_mul();
    test_backpressure();
    test_illegal_shr();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
